// File: rtl/systolic_skew_feeder.sv
// Systolic array edge feeder: skews LANES-wide operand vectors diagonally,
// counts K_DEPTH vectors per tile, drains the skew pipeline, then pulses finish.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int K_DEPTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [LANES-1:0]            out_valid,
  output logic                        finish,
  output logic                        busy
);

  localparam int VEC_W = $clog2(K_DEPTH + 1);
  localparam int DRN_W = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [VEC_W-1:0] vec_cnt, vec_cnt_nxt;
  logic [DRN_W-1:0] drain_cnt, drain_cnt_nxt;
  logic             accept;

  assign in_ready = !rst && ((state == IDLE) || (state == FEED));
  assign accept   = in_valid && in_ready;

  // finish and busy are decoded from the state register only, so neither can
  // glitch from in_valid.
  assign finish = (state == FIN);
  assign busy   = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vec_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      vec_cnt   <= vec_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // NOTE: every variable written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt     = state;
    vec_cnt_nxt   = vec_cnt;
    drain_cnt_nxt = drain_cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          vec_cnt_nxt = VEC_W'(1);
          if (K_DEPTH == 1) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = '0;
          end else begin
            state_nxt = FEED;
          end
        end
      end
      FEED: begin
        if (accept) begin
          vec_cnt_nxt = vec_cnt + VEC_W'(1);
          if (vec_cnt == VEC_W'(K_DEPTH - 1)) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = '0;
          end
        end
      end
      DRAIN: begin
        drain_cnt_nxt = drain_cnt + DRN_W'(1);
        if (drain_cnt == DRN_W'(LANES - 1)) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt   = IDLE;
        vec_cnt_nxt = '0;
      end
      default: begin
        state_nxt     = IDLE;
        vec_cnt_nxt   = '0;
        drain_cnt_nxt = '0;
      end
    endcase
  end

  // Lane i is a chain of i+1 registers; a bubble shifts in zero with valid low.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] stage_d [0:i];
    logic                  stage_v [0:i];

    // NOTE: the skew chains are reset explicitly because a reset mid-tile must
    // discard the partial tile and present zeros at once, not stale operands.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          stage_d[j] <= '0;
          stage_v[j] <= 1'b0;
        end
      end else begin
        stage_d[0] <= accept ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        stage_v[0] <= accept;
        for (int j = 1; j <= i; j++) begin
          stage_d[j] <= stage_d[j-1];
          stage_v[j] <= stage_v[j-1];
        end
      end
    end

    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = stage_d[i];
    assign out_valid[i]                         = stage_v[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: a tile-level timing model predicts
// each lane element, finish pulse, in_ready and busy; a negedge monitor compares.
module tb_systolic_skew_feeder;

  localparam int DW    = 16;
  localparam int LANES = 4;
  localparam int K     = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data = '0;
  logic [LANES*DW-1:0]   out_data;
  logic [LANES-1:0]      out_valid;
  logic                  finish;
  logic                  busy;

  // single-lane, single-vector instance
  logic                  in_valid1 = 1'b0;
  logic                  in_ready1;
  logic [DW-1:0]         in_data1 = '0;
  logic [DW-1:0]         out_data1;
  logic [0:0]            out_valid1;
  logic                  finish1;
  logic                  busy1;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .LANES(LANES), .K_DEPTH(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .finish(finish), .busy(busy)
  );

  systolic_skew_feeder #(.DATA_WIDTH(DW), .LANES(1), .K_DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_data(out_data1), .out_valid(out_valid1),
    .finish(finish1), .busy(busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
  } exp_t;

  exp_t lane_q [LANES][$];
  int   fin_q [$];
  int   cyc = 0;
  int   ready_from = 0;
  int   acc_in_tile = 0;
  bit   mon_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from tile timing alone.
  task automatic drive(input logic v, input logic [LANES*DW-1:0] d);
    int t;
    bit acc;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    t   = cyc;
    acc = v && (t >= ready_from);
    @(posedge clk);
    #1;
    if (acc) begin
      for (int i = 0; i < LANES; i++) lane_q[i].push_back('{cyc: t + 1 + i, d: d[i*DW +: DW]});
      acc_in_tile++;
      if (acc_in_tile == K) begin
        fin_q.push_back(t + LANES + 1);
        ready_from  = t + LANES + 2;
        acc_in_tile = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    mon_en   = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_out_data", {31'd0, |out_data}, 32'd0);
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_finish", {31'd0, finish}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < LANES; i++) lane_q[i].delete();
    fin_q.delete();
    acc_in_tile = 0;
    ready_from  = 0;
    mon_en      = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      for (int i = 0; i < LANES; i++) begin
        if (out_valid[i]) begin
          if (lane_q[i].size() == 0) begin
            check($sformatf("lane%0d_spurious", i), 32'd1, 32'd0);
          end else if (lane_q[i][0].cyc != cyc) begin
            check($sformatf("lane%0d_timing", i), cyc, lane_q[i][0].cyc);
            if (lane_q[i][0].cyc < cyc) void'(lane_q[i].pop_front());
          end else begin
            exp_t e;
            e = lane_q[i].pop_front();
            check($sformatf("lane%0d_data", i), {16'd0, out_data[i*DW +: DW]}, {16'd0, e.d});
          end
        end else begin
          check($sformatf("lane%0d_bubble_zero", i), {16'd0, out_data[i*DW +: DW]}, 32'd0);
          if (lane_q[i].size() > 0 && lane_q[i][0].cyc <= cyc) begin
            check($sformatf("lane%0d_valid", i), 32'd0, 32'd1);
            void'(lane_q[i].pop_front());
          end
        end
      end
      if (fin_q.size() > 0 && fin_q[0] <= cyc) begin
        check("finish_pulse", {31'd0, finish}, 32'd1);
        void'(fin_q.pop_front());
      end else begin
        check("finish_quiet", {31'd0, finish}, 32'd0);
      end
      check("in_ready", {31'd0, in_ready}, {31'd0, cyc >= ready_from});
      check("busy", {31'd0, busy}, {31'd0, (acc_in_tile > 0) || (cyc < ready_from)});
    end
  end

  function automatic logic [LANES*DW-1:0] vec(input int a, input int b, input int c, input int d);
    return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0);
  endtask

  initial begin
    // reset, then idle
    do_reset();
    idle(3);

    // three back-to-back vectors
    drive(1'b1, vec(1, 2, 3, 4));
    drive(1'b1, vec(5, 6, 7, 8));
    drive(1'b1, vec(9, 10, 11, 12));
    idle(8);

    // one bubble inside the tile
    drive(1'b1, vec(1, 2, 3, 4));
    drive(1'b0, vec(99, 99, 99, 99));
    drive(1'b1, vec(5, 6, 7, 8));
    drive(1'b1, vec(9, 10, 11, 12));
    idle(8);

    // in_valid held high across several tiles
    for (int k = 0; k < 24; k++) drive(1'b1, vec(100 + k, 200 + k, 300 + k, 400 + k));
    idle(8);

    // reset in DRAIN, then a clean tile
    drive(1'b1, vec(7, 7, 7, 7));
    drive(1'b1, vec(8, 8, 8, 8));
    drive(1'b1, vec(9, 9, 9, 9));
    drive(1'b0, '0);
    do_reset();
    idle(2);
    drive(1'b1, vec(1, 2, 3, 4));
    drive(1'b1, vec(5, 6, 7, 8));
    drive(1'b1, vec(9, 10, 11, 12));
    idle(8);

    // randomized traffic, including full-scale values
    for (int k = 0; k < 200; k++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom});
    end
    idle(10);

    for (int i = 0; i < LANES; i++) check($sformatf("lane%0d_leftover", i), lane_q[i].size(), 32'd0);
    check("finish_leftover", fin_q.size(), 32'd0);

    // single-lane, single-vector tile
    @(negedge clk);
    in_valid1 = 1'b1;
    in_data1  = 16'hFFFF;
    @(negedge clk);
    in_valid1 = 1'b0;
    in_data1  = '0;
    check("k1_data", {16'd0, out_data1}, 32'h0000_FFFF);
    check("k1_valid", {31'd0, out_valid1}, 32'd1);
    check("k1_finish_early", {31'd0, finish1}, 32'd0);
    check("k1_ready_drain", {31'd0, in_ready1}, 32'd0);
    @(negedge clk);
    check("k1_finish", {31'd0, finish1}, 32'd1);
    check("k1_valid_off", {31'd0, out_valid1}, 32'd0);
    check("k1_data_off", {16'd0, out_data1}, 32'd0);
    @(negedge clk);
    check("k1_finish_end", {31'd0, finish1}, 32'd0);
    check("k1_ready_idle", {31'd0, in_ready1}, 32'd1);
    check("k1_busy_idle", {31'd0, busy1}, 32'd0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
